ac_motor_gate_guard: RTL

AC_MOTOR_GATE_GUARD -- requirements
Module: ac_motor_gate_guard

---
 rtl/ac_motor_gate_guard_pkg.sv | 13 +
 rtl/ac_motor_gate_guard_phase.sv | 46 ++++
 rtl/ac_motor_gate_guard.sv | 115 +++++++++++
 3 files changed

// File: rtl/ac_motor_gate_guard_pkg.sv
// Shared definitions for the three-phase gate guard: state encoding and fault type codes.
package ac_motor_gate_guard_pkg;

   typedef enum logic [1:0] {
      StArm   = 2'd0,
      StRun   = 2'd1,
      StFault = 2'd2
   } state_e;

   localparam logic FaultDeadTime     = 1'b0;
   localparam logic FaultShootThrough = 1'b1;

endpackage

// File: rtl/ac_motor_gate_guard_phase.sv
// One phase of the gate guard: off-time counter, edge detect and violation flags.
module ac_motor_gate_guard_phase #(
   parameter int unsigned DEAD_W = 11
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s_high,
   input  logic              s_low,
   input  logic [DEAD_W-1:0] min_dead,
   output logic              shoot,
   output logic              dead_viol
);

   localparam logic [DEAD_W-1:0] CntOne = {{(DEAD_W-1){1'b0}}, 1'b1};
   localparam logic [DEAD_W-1:0] CntMax = '1;

   logic [DEAD_W-1:0] off_cnt_q;
   logic              high_q;
   logic              low_q;
   logic              rise;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         off_cnt_q <= '0;
         high_q    <= 1'b0;
         low_q     <= 1'b0;
      end else begin
         high_q <= s_high;
         low_q  <= s_low;
         if (s_high || s_low) begin
            off_cnt_q <= '0;
         end else if (off_cnt_q != CntMax) begin
            off_cnt_q <= off_cnt_q + CntOne;
         end
      end
   end

   // off_cnt_q holds the all-off cycles before this one, so a direct
   // switch-over sees 0 here and is flagged whenever min_dead is non-zero.
   always_comb begin
      rise      = (s_high && !high_q) || (s_low && !low_q);
      shoot     = s_high && s_low;
      dead_viol = rise && (min_dead != '0) && (off_cnt_q < min_dead);
   end

endmodule

// File: rtl/ac_motor_gate_guard.sv
// Three-phase gate drive guard: arms after a quiet period, forwards gate requests,
// and latches a fault on shoot-through or dead-time violation.
module ac_motor_gate_guard
   import ac_motor_gate_guard_pkg::*;
#(
   parameter int unsigned DEAD_W = 11
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        s_high,
   input  logic [2:0]        s_low,
   input  logic [DEAD_W-1:0] min_dead,
   input  logic              fault_clear,
   output logic [2:0]        g_high,
   output logic [2:0]        g_low,
   output logic              enable,
   output logic              fault,
   output logic [2:0]        fault_phase,
   output logic              fault_type
);

   localparam logic [DEAD_W-1:0] CntOne = {{(DEAD_W-1){1'b0}}, 1'b1};
   localparam logic [DEAD_W-1:0] CntMax = '1;

   state_e            state_q;
   logic [DEAD_W-1:0] arm_cnt_q;
   logic [2:0]        shoot;
   logic [2:0]        dead_viol;
   logic              any_viol;
   logic              all_low;

   for (genvar p = 0; p < 3; p++) begin : g_phase
      ac_motor_gate_guard_phase #(
         .DEAD_W (DEAD_W)
      ) u_phase (
         .clk       (clk),
         .reset_n   (reset_n),
         .s_high    (s_high[p]),
         .s_low     (s_low[p]),
         .min_dead  (min_dead),
         .shoot     (shoot[p]),
         .dead_viol (dead_viol[p])
      );
   end

   always_comb begin
      any_viol = |{shoot, dead_viol};
      all_low  = ~|{s_high, s_low};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StArm;
         arm_cnt_q   <= '0;
         g_high      <= 3'b000;
         g_low       <= 3'b000;
         enable      <= 1'b0;
         fault       <= 1'b0;
         fault_phase <= 3'b000;
         fault_type  <= FaultDeadTime;
      end else begin
         unique case (state_q)
            StArm: begin
               g_high <= 3'b000;
               g_low  <= 3'b000;
               enable <= 1'b0;
               if (!all_low) begin
                  arm_cnt_q <= '0;
               end else if (arm_cnt_q >= min_dead) begin
                  state_q   <= StRun;
                  enable    <= 1'b1;
                  arm_cnt_q <= '0;
               end else if (arm_cnt_q != CntMax) begin
                  arm_cnt_q <= arm_cnt_q + CntOne;
               end
            end
            StRun: begin
               if (any_viol) begin
                  state_q     <= StFault;
                  g_high      <= 3'b000;
                  g_low       <= 3'b000;
                  enable      <= 1'b0;
                  fault       <= 1'b1;
                  fault_phase <= shoot | dead_viol;
                  fault_type  <= (|shoot) ? FaultShootThrough : FaultDeadTime;
               end else begin
                  // Shoot-through counts as a violation, so both sides never pass together.
                  g_high <= s_high;
                  g_low  <= s_low;
                  enable <= 1'b1;
               end
            end
            StFault: begin
               g_high <= 3'b000;
               g_low  <= 3'b000;
               enable <= 1'b0;
               if (fault_clear && all_low) begin
                  state_q     <= StArm;
                  arm_cnt_q   <= '0;
                  fault       <= 1'b0;
                  fault_phase <= 3'b000;
                  fault_type  <= FaultDeadTime;
               end
            end
            default: begin
               state_q <= StArm;
               g_high  <= 3'b000;
               g_low   <= 3'b000;
               enable  <= 1'b0;
            end
         endcase
      end
   end

endmodule
